// File: rtl/led_value_sequencer.sv
// Timed 4-bit pattern engine (up / down / rotate / bounce) with parallel load and manual step.
// Define LED_SEQ_DEBOUNCE_EN to pass step through a synchronizer and debouncer before edge detection.
module led_value_sequencer #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       step,
    output logic [3:0] value,
    output logic       tick,
    output logic       wrap
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
        $error("DEB_CYCLES must be at least 1");
    end

    // Returns {next_dir_up, wrap, next_value} for one advance in the given mode.
    function automatic logic [5:0] advance_fn(input logic [3:0] v,
                                              input logic [1:0] m,
                                              input logic       up);
        logic [3:0] nv;
        logic       nup;
        logic       w;
        nv  = v;
        nup = up;
        w   = 1'b0;
        case (m)
            2'b00: begin
                nv = v + 4'd1;
                w  = (v == 4'hF);
            end
            2'b01: begin
                nv = v - 4'd1;
                w  = (v == 4'h0);
            end
            2'b10: begin
                nv = (v == 4'h0) ? 4'h1 : {v[2:0], v[3]};
                w  = (v == 4'h8);
            end
            default: begin
                if (up) begin
                    if (v == 4'hF) begin
                        nv  = 4'hE;
                        nup = 1'b0;
                    end else begin
                        nv  = v + 4'd1;
                        nup = (nv != 4'hF);
                    end
                end else begin
                    if (v == 4'h0) begin
                        nv  = 4'h1;
                        nup = 1'b1;
                    end else begin
                        nv  = v - 4'd1;
                        nup = (nv == 4'h0);
                    end
                end
                w = (nv == 4'hF) || (nv == 4'h0);
            end
        endcase
        return {nup, w, nv};
    endfunction

    logic [CNT_W-1:0] cnt;
    logic             dir_up;
    logic [1:0]       mode_prev;
    logic             step_rise;

`ifdef LED_SEQ_DEBOUNCE_EN
    localparam int                DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             step_p0;
    logic             step_p1;
    logic             step_deb;
    logic             step_deb_d;
    logic [DEB_W-1:0] deb_cnt;

    // Synchronizer stage, then the level must disagree for DEB_CYCLES samples in a row to flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_p0    <= 1'b0;
            step_p1    <= 1'b0;
            step_deb   <= 1'b0;
            step_deb_d <= 1'b0;
            deb_cnt    <= '0;
        end else begin
            step_p0    <= step;
            step_p1    <= step_p0;
            step_deb_d <= step_deb;
            if (step_p1 == step_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                step_deb <= step_p1;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign step_rise = step_deb & ~step_deb_d;
`else
    logic step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_d <= 1'b0;
        end else begin
            step_d <= step;
        end
    end

    assign step_rise = step & ~step_d;
`endif

    logic       tick_due;
    logic       adv;
    logic       eff_up;
    logic [5:0] adv_bits;

    always_comb begin
        tick_due = en && (cnt == CNT_LAST);
        adv      = tick_due || (!en && step_rise);
        eff_up   = ((mode == 2'b11) && (mode_prev != 2'b11)) ? 1'b1 : dir_up;
        adv_bits = advance_fn(value, mode, eff_up);
    end

    // Load outranks any advance that lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            value     <= 4'h0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            dir_up    <= 1'b1;
            mode_prev <= 2'b00;
        end else begin
            mode_prev <= mode;
            if (load) begin
                value  <= load_val;
                cnt    <= '0;
                tick   <= 1'b0;
                wrap   <= 1'b0;
                dir_up <= 1'b1;
            end else begin
                cnt    <= (!en || tick_due) ? '0 : cnt + CNT_W'(1);
                tick   <= adv;
                wrap   <= adv && adv_bits[4];
                dir_up <= adv ? adv_bits[5] : eff_up;
                if (adv) begin
                    value <= adv_bits[3:0];
                end
            end
        end
    end

endmodule
